// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared widths, latency, identity bank and rounding helpers for matrix_vec_pipe
package matrix_pkg;

   localparam int DEF_N      = 2;
   localparam int DEF_IN_W   = 13;
   localparam int DEF_COEF_W = 19;
   localparam int DEF_FRAC   = 14;
   localparam int DEF_OUT_W  = 17;

   // Banks are built at the largest supported size and sliced down by the user.
   localparam int MAX_N      = 4;
   localparam int MAX_COEF_W = 32;

   // Row-major coefficient image, element r*N+c at [(r*N+c)*COEF_W +: COEF_W].
   typedef logic [MAX_N*MAX_N*MAX_COEF_W-1:0] coef_bank_t;

   localparam longint DEF_ROUND_OFS = longint'(1) << (DEF_FRAC - 1);

   function automatic int lat(input int n);
      return 4 + $clog2(n);
   endfunction

   function automatic longint round_ofs(input int frac);
      return longint'(1) << (frac - 1);
   endfunction

   // Diagonal of 2^frac is a single set bit inside each diagonal element.
   function automatic coef_bank_t identity_bank(input int n, input int coef_w, input int frac);
      coef_bank_t b;
      b = '0;
      for (int r = 0; r < n; r++) begin
         b[(r*n + r)*coef_w + frac] = 1'b1;
      end
      return b;
   endfunction

endpackage

// File: rtl/matrix_vec_pipe_if.sv
// rtl/matrix_vec_pipe_if.sv - sample stream and coefficient-load bus; sat_flag present only with MATRIX_VEC_SAT_EN
interface matrix_vec_pipe_if
   import matrix_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int IN_W   = DEF_IN_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int OUT_W  = DEF_OUT_W
);

   logic                        in_valid;
   logic [N*IN_W-1:0]           in_vec;
   logic                        coef_we;
   logic [$clog2(N*N)-1:0]      coef_addr;
   logic signed [COEF_W-1:0]    coef_data;
   logic                        coef_commit;
   logic                        out_valid;
   logic [N*OUT_W-1:0]          out_vec;
`ifdef MATRIX_VEC_SAT_EN
   logic [N-1:0]                sat_flag;
`endif

`ifdef MATRIX_VEC_SAT_EN
   modport master (
      output in_valid, in_vec, coef_we, coef_addr, coef_data, coef_commit,
      input  out_valid, out_vec, sat_flag
   );
   modport slave (
      input  in_valid, in_vec, coef_we, coef_addr, coef_data, coef_commit,
      output out_valid, out_vec, sat_flag
   );
`else
   modport master (
      output in_valid, in_vec, coef_we, coef_addr, coef_data, coef_commit,
      input  out_valid, out_vec
   );
   modport slave (
      input  in_valid, in_vec, coef_we, coef_addr, coef_data, coef_commit,
      output out_valid, out_vec
   );
`endif

endinterface

// File: rtl/matrix_row_dot.sv
// rtl/matrix_row_dot.sv - one output row: N multipliers, registered adder tree, round and limit (clamp with MATRIX_VEC_SAT_EN, else wrap)
module matrix_row_dot
   import matrix_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int IN_W   = DEF_IN_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int FRAC   = DEF_FRAC,
   parameter int OUT_W  = DEF_OUT_W
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N*IN_W-1:0]        i_x,
   input  logic [N*COEF_W-1:0]      i_c,
   input  logic                     i_out_en,
   output logic signed [OUT_W-1:0]  o_y
`ifdef MATRIX_VEC_SAT_EN
   ,
   output logic                     o_sat
`endif
);

   localparam int PROD_W = IN_W + COEF_W;
   localparam int LVL    = $clog2(N);
   localparam int P      = 1 << LVL;
   localparam int ACC_W  = PROD_W + LVL;
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(round_ofs(FRAC));

   logic signed [PROD_W-1:0] r_prod [N];
   // Heap-ordered tree: leaves at P-1..2P-2, root at 0; every node is one register deep.
   logic signed [ACC_W-1:0]  r_node [2*P-1];
   logic signed [ACC_W-1:0]  w_sum;
   logic signed [ACC_W-1:0]  w_sh;

   // first multiply stage: full-precision signed products
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < N; c++) r_prod[c] <= '0;
      end else begin
         for (int c = 0; c < N; c++) begin
            r_prod[c] <= PROD_W'($signed(i_x[c*IN_W +: IN_W])) *
                         PROD_W'($signed(i_c[c*COEF_W +: COEF_W]));
         end
      end
   end

   // second multiply stage loads the leaves; inner nodes sum their children each cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2*P-1; i++) r_node[i] <= '0;
      end else begin
         for (int j = 0; j < N; j++) r_node[P-1+j] <= ACC_W'(r_prod[j]);
         for (int j = N; j < P; j++) r_node[P-1+j] <= '0;
         for (int i = 0; i < P-1; i++) r_node[i] <= r_node[2*i+1] + r_node[2*i+2];
      end
   end

   assign w_sum = r_node[0] + RND;
   assign w_sh  = w_sum >>> FRAC;

`ifdef MATRIX_VEC_SAT_EN
   localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((longint'(1) << (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

   // output stage: clamp to the output range and flag the row when clamped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_y   <= '0;
         o_sat <= 1'b0;
      end else if (i_out_en) begin
         if (w_sh > Y_MAX) begin
            o_y   <= Y_MAX[OUT_W-1:0];
            o_sat <= 1'b1;
         end else if (w_sh < Y_MIN) begin
            o_y   <= Y_MIN[OUT_W-1:0];
            o_sat <= 1'b1;
         end else begin
            o_y   <= w_sh[OUT_W-1:0];
            o_sat <= 1'b0;
         end
      end
   end
`else
   // Bits above the output width are deliberately dropped when wrapping.
   logic w_unused;
   assign w_unused = ^w_sh[ACC_W-1:OUT_W];

   // output stage: keep the low OUT_W bits of the rounded sum
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_y <= '0;
      end else if (i_out_en) begin
         o_y <= w_sh[OUT_W-1:0];
      end
   end
`endif

endmodule

// File: rtl/matrix_vec_pipe.sv
// rtl/matrix_vec_pipe.sv - streaming NxN matrix times vector with shadow/active coefficient banks; MATRIX_VEC_SAT_EN adds saturation
module matrix_vec_pipe
   import matrix_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int IN_W   = DEF_IN_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int FRAC   = DEF_FRAC,
   parameter int OUT_W  = DEF_OUT_W
)
(
   input  logic             clk,
   input  logic             rst,
   matrix_vec_pipe_if.slave bus
);

   localparam int LAT    = lat(N);
   localparam int BANK_W = N*N*COEF_W;
   localparam logic [BANK_W-1:0] IDENT = BANK_W'(identity_bank(N, COEF_W, FRAC));

   logic [BANK_W-1:0]  r_shadow;
   logic [BANK_W-1:0]  r_active;
   logic [BANK_W-1:0]  w_shadow_nxt;
   logic [BANK_W-1:0]  r_c;
   logic [N*IN_W-1:0]  r_x;
   logic [LAT-1:0]     r_vld;
   logic [N*OUT_W-1:0] w_out_vec;
`ifdef MATRIX_VEC_SAT_EN
   logic [N-1:0]       w_sat;
   assign bus.sat_flag = w_sat;
`endif

   // shadow image including this cycle's write, so a same-cycle commit copies it
   always_comb begin
      w_shadow_nxt = r_shadow;
      if (bus.coef_we && (int'(bus.coef_addr) < N*N)) begin
         w_shadow_nxt[int'(bus.coef_addr)*COEF_W +: COEF_W] = bus.coef_data;
      end
   end

   // coefficient banks; a commit replaces the whole active bank at one edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow <= IDENT;
         r_active <= IDENT;
      end else begin
         r_shadow <= w_shadow_nxt;
         if (bus.coef_commit) r_active <= w_shadow_nxt;
      end
   end

   // capture stage: the sample travels with the bank that was active when it arrived
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x <= '0;
         r_c <= '0;
      end else if (bus.in_valid) begin
         r_x <= bus.in_vec;
         r_c <= r_active;
      end
   end

   // valid pipeline, one bit per register stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
      end else begin
         r_vld <= {r_vld[LAT-2:0], bus.in_valid};
      end
   end

   for (genvar r = 0; r < N; r++) begin : g_row
      matrix_row_dot #(
         .N      (N),
         .IN_W   (IN_W),
         .COEF_W (COEF_W),
         .FRAC   (FRAC),
         .OUT_W  (OUT_W)
      ) u_row (
         .clk      (clk),
         .rst      (rst),
         .i_x      (r_x),
         .i_c      (r_c[r*N*COEF_W +: N*COEF_W]),
         .i_out_en (r_vld[LAT-2]),
         .o_y      (w_out_vec[r*OUT_W +: OUT_W])
`ifdef MATRIX_VEC_SAT_EN
         ,
         .o_sat    (w_sat[r])
`endif
      );
   end

   assign bus.out_valid = r_vld[LAT-1];
   assign bus.out_vec   = w_out_vec;

endmodule
